// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch control: owns fetch PC, one outstanding imem request,
// valid/ready hand-off to decode, then waits for dnpc commit.
//
// Ports:
//   clk, rst                       core clock, sync active-high reset
//   imem_req_valid/ready, imem_addr  fetch request channel
//   imem_rsp_valid/data/err        fetch response channel
//   inst_valid/ready, inst, inst_pc, inst_fault  hand-off to decode
//   dnpc_valid, dnpc               next-PC commit from writeback
//   fetch_cnt                      instructions accepted by decode
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_COMMIT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        flt_q, flt_d;
  logic        misal;

  assign misal = |pc_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      flt_q   <= flt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    flt_d   = flt_q;
    unique case (state_q)
      S_REQ: begin
        if (misal) begin
          inst_d  = '0;
          ipc_d   = pc_q;
          flt_d   = 1'b1;
          state_d = S_OUT;
        end else if (imem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response on the timeout cycle takes priority over the fault.
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_err ? 32'h0 : imem_rsp_data;
          ipc_d   = pc_q;
          flt_d   = imem_rsp_err;
          state_d = S_OUT;
        end else if (cnt_q == TO_LAST) begin
          inst_d  = '0;
          ipc_d   = pc_q;
          flt_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          fcnt_d  = fcnt_q + 32'd1;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (dnpc_valid) begin
          pc_d    = dnpc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ) && !rst && !misal;
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_q;
  assign inst_pc        = ipc_q;
  assign inst_fault     = flt_q;
  assign fetch_cnt      = fcnt_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed self-checking bench for ifu_fetch_ctrl (TIMEOUT=4).
// Each step: clock edge, check outputs, then drive the next inputs.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        dnpc_valid;
  logic [31:0] dnpc;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  ifu_fetch_ctrl #(
    .RESET_PC(32'h80000000),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_fault    (inst_fault),
    .dnpc_valid    (dnpc_valid),
    .dnpc          (dnpc),
    .fetch_cnt     (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] i,
                         input logic [31:0] pc, input logic f);
    chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
    chk({tag, ".inst"}, inst, i);
    chk({tag, ".pc"}, inst_pc, pc);
    chk({tag, ".fault"}, 32'(inst_fault), 32'(f));
  endtask

  // From OUT: accept, then commit npc; leaves DUT in REQ at npc.
  task automatic accept_commit(input logic [31:0] npc,
                               input logic [31:0] cnt);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("acc.cnt", fetch_cnt, cnt);
    chk("acc.vld", 32'(inst_valid), 32'd0);
    dnpc_valid = 1'b1;
    dnpc       = npc;
    tick();
    dnpc_valid = 1'b0;
    chk("cmt.addr", imem_addr, npc);
  endtask

  initial begin
    logic [31:0] hold_i;
    logic [31:0] hold_pc;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    dnpc_valid     = 1'b0;
    dnpc           = '0;

    // 1. reset and first fetch
    tick();
    tick();
    chk("rst.reqv", 32'(imem_req_valid), 32'd0);
    chk("rst.ivld", 32'(inst_valid), 32'd0);
    chk("rst.addr", imem_addr, 32'h80000000);
    chk("rst.cnt", fetch_cnt, 32'd0);
    chk("rst.inst", inst, 32'd0);
    chk("rst.pc", inst_pc, 32'd0);
    chk("rst.flt", 32'(inst_fault), 32'd0);
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("req.reqv", 32'(imem_req_valid), 32'd1);
    tick();
    chk("wait.reqv", 32'(imem_req_valid), 32'd0);
    chk("wait.ivld", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00100093;
    tick();
    imem_rsp_valid = 1'b0;
    chk_out("t1", 32'h00100093, 32'h80000000, 1'b0);

    // 2. backpressure
    hold_i  = inst;
    hold_pc = inst_pc;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp.inst", inst, hold_i);
      chk("bp.pc", inst_pc, hold_pc);
      chk("bp.cnt", fetch_cnt, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("bp.cnt1", fetch_cnt, 32'd1);
    chk("bp.reqv", 32'(imem_req_valid), 32'd0);
    tick();
    chk("bp.cnt1b", fetch_cnt, 32'd1);
    chk("cmt.ivld", 32'(inst_valid), 32'd0);

    // 3. dnpc ignored in WAIT, honoured in COMMIT
    dnpc_valid = 1'b1;
    dnpc       = 32'h80000004;
    tick();
    dnpc_valid     = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    dnpc_valid     = 1'b1;
    dnpc           = 32'h80000100;
    tick();
    dnpc_valid = 1'b0;
    chk("w.dnpc.addr", imem_addr, 32'h80000004);
    chk("w.dnpc.ivld", 32'(inst_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00000013;
    tick();
    imem_rsp_valid = 1'b0;
    chk_out("t3", 32'h00000013, 32'h80000004, 1'b0);
    accept_commit(32'h80000010, 32'd2);
    chk("t3.reqv", 32'(imem_req_valid), 32'd1);

    // 5a. bus error
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk_out("err", 32'd0, 32'h80000010, 1'b1);
    accept_commit(32'h80000006, 32'd3);

    // 4. misaligned
    chk("mis.reqv", 32'(imem_req_valid), 32'd0);
    chk("mis.ivld0", 32'(inst_valid), 32'd0);
    tick();
    chk_out("mis", 32'd0, 32'h80000006, 1'b1);
    accept_commit(32'h80000020, 32'd4);

    // 5b. timeout, 4 cycles after entering WAIT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("to.ivld0", 32'(inst_valid), 32'd0);
      tick();
    end
    chk("to.ivld3", 32'(inst_valid), 32'd0);
    tick();
    chk_out("to", 32'd0, 32'h80000020, 1'b1);
    accept_commit(32'h80000024, 32'd5);

    // 5c. response on the timeout cycle wins
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    tick();
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h12345678;
    tick();
    imem_rsp_valid = 1'b0;
    chk_out("tor", 32'h12345678, 32'h80000024, 1'b0);
    accept_commit(32'h80000028, 32'd6);

    // 6. reset mid-WAIT, late response dropped
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst            = 1'b1;
    tick();
    chk("r6.reqv", 32'(imem_req_valid), 32'd0);
    chk("r6.cnt", fetch_cnt, 32'd0);
    chk("r6.addr", imem_addr, 32'h80000000);
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAA5555;
    tick();
    imem_rsp_valid = 1'b0;
    chk("r6.ivld", 32'(inst_valid), 32'd0);
    chk("r6.reqv1", 32'(imem_req_valid), 32'd1);
    chk("r6.inst", inst, 32'd0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00200113;
    tick();
    imem_rsp_valid = 1'b0;
    chk_out("r6f", 32'h00200113, 32'h80000000, 1'b0);
    accept_commit(32'h80000004, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Instruction fetch unit that sits directly upstream of the decode stage. It owns the fetch PC, issues single-outstanding requests to instruction memory and hands each 32-bit instruction plus its PC to decode over a valid/ready handshake. It then waits for commit of the next PC (dnpc) from writeback before fetching again, so the core runs as a multi-cycle, non-pipelined machine.

Parameters:
RESET_PC, 32'h80000000, fetch address loaded on reset
TIMEOUT, 255, maximum cycles in WAIT before a fetch fault is raised (range 1..255)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address, equals fetch_pc
imem_rsp_valid  in  1  response valid
imem_rsp_data  in  32  fetched instruction word
imem_rsp_err  in  1  bus error, qualified by imem_rsp_valid
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  instruction word to decode
inst_pc  out  32  PC of inst
inst_fault  out  1  fetch fault (misaligned, bus error, timeout); inst forced to 0
dnpc_valid  in  1  writeback commit pulse, next PC valid
dnpc  in  32  next PC from execute/writeback
fetch_cnt  out  32  count of instructions accepted by decode

Behaviour:
- Clocking: all state is on posedge clk. rst is synchronous and active-high and has priority over every other input.
- Reset values:
  - state=REQ, fetch_pc=RESET_PC, timeout counter=0, fetch_cnt=0.
  - inst=0, inst_pc=0, inst_fault=0, inst_valid=0.
  - imem_req_valid=0 during any cycle rst is high.
- Output decoding:
  - imem_req_valid=1 only in REQ with rst low.
  - inst_valid=1 only in OUT.
  - imem_addr=fetch_pc at all times.
- States: REQ, WAIT, OUT, COMMIT.
- REQ:
  - If fetch_pc[1:0]!=0: issue no request. Latch inst=0, inst_pc=fetch_pc, inst_fault=1. Go to OUT.
  - Else assert imem_req_valid. On imem_req_ready=1, clear the timeout counter and go to WAIT. Otherwise hold; the request stays stable.
- WAIT:
  - imem_rsp_valid=1: latch inst=imem_rsp_data (0 if imem_rsp_err), inst_pc=fetch_pc, inst_fault=imem_rsp_err. Go to OUT.
  - Else increment the counter. When the counter reaches TIMEOUT-1 with no response: latch inst=0, inst_fault=1, inst_pc=fetch_pc, go to OUT.
  - If the response and timeout coincide, the response wins.
  - A response is accepted no earlier than the cycle after the request handshake. imem_rsp_valid in any state other than WAIT is ignored.
- OUT:
  - inst, inst_pc and inst_fault are stable while inst_valid=1 and inst_ready=0.
  - On inst_valid&&inst_ready: fetch_cnt+=1 (wraps 32'hFFFFFFFF->0), go to COMMIT.
- COMMIT:
  - On dnpc_valid: fetch_pc=dnpc, go to REQ.
  - dnpc_valid in any other state is ignored and does not alter fetch_pc.
- Latency (zero-wait memory, rsp one cycle after req): request in cycle N, inst_valid in cycle N+2. With inst_ready=1, COMMIT is entered at N+3.
- Reset mid-operation: an outstanding response arriving after rst is dropped (state is REQ, not WAIT). The next request goes to RESET_PC.
- fetch_pc is written only in reset and in COMMIT.

Test Plan:
1. Reset sequence: rst high 2 cycles, then low; imem_req_ready=1, rsp=32'h00100093 one cycle later -> imem_addr=32'h80000000, inst_valid 2 cycles after the request, inst=32'h00100093, inst_pc=32'h80000000, inst_fault=0.
2. Backpressure: inst_ready=0 for 5 cycles in OUT, then 1 -> inst/inst_pc constant throughout, fetch_cnt 0->1 exactly once, then state COMMIT with imem_req_valid=0.
3. Commit redirect: dnpc_valid pulse in WAIT with dnpc=32'h80000100 (ignored), then in COMMIT with dnpc=32'h80000010 -> next imem_addr=32'h80000010.
4. Misaligned: dnpc=32'h80000006 committed -> no imem_req_valid asserted, inst_valid next cycle with inst=0, inst_fault=1, inst_pc=32'h80000006.
5. Faults: rsp_err=1 with data 32'hDEADBEEF -> inst=0, inst_fault=1. No response for TIMEOUT=4 -> fault exactly 4 cycles after entering WAIT. rsp_valid on the timeout cycle -> data delivered, fault=0.
6. Reset mid-WAIT: rst during WAIT, response arrives in the cycle after rst deasserts -> ignored; new request to 32'h80000000; fetch_cnt=0.
